// File: rtl/snake_body_pkg.sv
// ---------------------------------------------------------------------------
// snake_body_pkg
// Purpose : Shared grid geometry, direction/state encodings and small
//           movement helpers for the snake body controller.
// Contents: grid and buffer constants, dir_e (heading), state_e (controller
//           FSM), neighbour-cell / wall / reversal helper functions.
// ---------------------------------------------------------------------------
package snake_body_pkg;

  // Grid geometry
  localparam int GRID_W    = 40;
  localparam int GRID_H    = 30;
  localparam int X_BITS    = 6;
  localparam int Y_BITS    = 5;

  // Segment buffer
  localparam int MAX_LEN   = 32;
  localparam int LEN_BITS  = 6;
  localparam int START_LEN = 3;
  localparam int START_X   = 20;
  localparam int START_Y   = 15;

  // Typed copies so comparisons stay width-exact
  localparam logic [X_BITS-1:0]   X_LAST    = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0]   Y_LAST    = Y_BITS'(GRID_H - 1);
  localparam logic [X_BITS-1:0]   X_START   = X_BITS'(START_X);
  localparam logic [LEN_BITS-1:0] LEN_START = LEN_BITS'(START_LEN);
  localparam logic [LEN_BITS-1:0] LEN_MAX   = LEN_BITS'(MAX_LEN);

  // Heading encoding: opposite directions share the upper bit
  typedef enum logic [1:0] {
    DIR_TOP   = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_CHECK = 2'd1,
    ST_DEAD  = 2'd2
  } state_e;

  // True when 'req' points straight back along 'held'
  function automatic logic is_reverse(input dir_e req, input dir_e held);
    logic r;
    r = 1'b0;
    case (held)
      DIR_TOP:   r = (req == DIR_DOWN);
      DIR_DOWN:  r = (req == DIR_TOP);
      DIR_LEFT:  r = (req == DIR_RIGHT);
      DIR_RIGHT: r = (req == DIR_LEFT);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  // True when moving from (x,y) in direction d would leave the grid
  function automatic logic hits_wall(input logic [X_BITS-1:0] x,
                                     input logic [Y_BITS-1:0] y,
                                     input dir_e d);
    logic r;
    r = 1'b0;
    case (d)
      DIR_TOP:   r = (y == '0);
      DIR_DOWN:  r = (y == Y_LAST);
      DIR_LEFT:  r = (x == '0);
      DIR_RIGHT: r = (x == X_LAST);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  // Neighbour x; only meaningful when hits_wall() is false
  function automatic logic [X_BITS-1:0] step_x(input logic [X_BITS-1:0] x,
                                               input dir_e d);
    logic [X_BITS-1:0] r;
    r = x;
    if (d == DIR_LEFT)  r = x - X_BITS'(1);
    if (d == DIR_RIGHT) r = x + X_BITS'(1);
    return r;
  endfunction

  // Neighbour y; y grows downwards
  function automatic logic [Y_BITS-1:0] step_y(input logic [Y_BITS-1:0] y,
                                               input dir_e d);
    logic [Y_BITS-1:0] r;
    r = y;
    if (d == DIR_TOP)  r = y - Y_BITS'(1);
    if (d == DIR_DOWN) r = y + Y_BITS'(1);
    return r;
  endfunction

endpackage

// File: rtl/snake_body_ctrl_seg_match.sv
// ---------------------------------------------------------------------------
// snake_seg_match
// Purpose : Parallel MAX_LEN-way comparator. Reports whether (cell_x,cell_y)
//           equals any live segment, i.e. any index below 'len'. Index 0
//           (the head) can be excluded for the self-collision check.
// Ports   : seg_x/seg_y  segment buffer, index 0 = head
//           len          number of live segments
//           cell_x/y     coordinate under test
//           hit          combinational match result
// ---------------------------------------------------------------------------
module snake_seg_match
  import snake_body_pkg::*;
#(
  parameter bit SKIP_HEAD = 1'b0
) (
  input  logic [MAX_LEN-1:0][X_BITS-1:0] seg_x,
  input  logic [MAX_LEN-1:0][Y_BITS-1:0] seg_y,
  input  logic [LEN_BITS-1:0]            len,
  input  logic [X_BITS-1:0]              cell_x,
  input  logic [Y_BITS-1:0]              cell_y,
  output logic                           hit
);

  logic [MAX_LEN-1:0] match;

  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
    localparam logic [LEN_BITS-1:0] IDX = LEN_BITS'(gi);
    if (SKIP_HEAD && gi == 0) begin : g_skip
      assign match[gi] = 1'b0;
    end else begin : g_live
      // Entries at or beyond 'len' are stale shift residue and never count
      assign match[gi] = (IDX < len) && (seg_x[gi] == cell_x) && (seg_y[gi] == cell_y);
    end
  end

  assign hit = |match;

endmodule

// File: rtl/snake_body_ctrl.sv
// ---------------------------------------------------------------------------
// snake_body_ctrl
// Purpose : Advances the snake one cell per 'step' tick along the debounced
//           heading, keeps the body in a shifting segment buffer, handles
//           growth, detects wall and self collisions, and answers per-cell
//           occupancy queries for the draw stage with one cycle of latency.
// Ports   : clk, rst_n            clock, asynchronous active-low reset
//           direction            requested heading (dir_e encoding)
//           step                 one-cycle move tick (period >= 3 cycles)
//           grow                 one-cycle food-eaten pulse
//           restart              one-cycle synchronous re-init, top priority
//           query_x/query_y      cell to test
//           query_hit/query_head registered: cell holds a live segment / head
//           head_x/head_y        current head cell
//           length               current length
//           moved                one-cycle pulse after a collision-free step
//           dead                 sticky game-over flag
// ---------------------------------------------------------------------------
module snake_body_ctrl
  import snake_body_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          direction,
  input  logic                step,
  input  logic                grow,
  input  logic                restart,
  input  logic [X_BITS-1:0]   query_x,
  input  logic [Y_BITS-1:0]   query_y,
  output logic                query_hit,
  output logic                query_head,
  output logic [X_BITS-1:0]   head_x,
  output logic [Y_BITS-1:0]   head_y,
  output logic [LEN_BITS-1:0] length,
  output logic                moved,
  output logic                dead
);

  // Segment buffer kept in flops: every entry shifts on the same edge
  logic [MAX_LEN-1:0][X_BITS-1:0] seg_x;
  logic [MAX_LEN-1:0][Y_BITS-1:0] seg_y;
  logic [LEN_BITS-1:0]            length_reg;
  dir_e                           heading;
  logic                           grow_pend;
  state_e                         state;

  // Initial body: a vertical column hanging below the start cell.
  // Entries past START_LEN only ever become live by shifting in real
  // segments, so their wrapped y values are irrelevant.
  logic [MAX_LEN-1:0][X_BITS-1:0] init_x;
  logic [MAX_LEN-1:0][Y_BITS-1:0] init_y;

  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_init
    assign init_x[gi] = X_START;
    assign init_y[gi] = Y_BITS'(START_Y + gi);
  end

  // Move decode from the current head
  dir_e              req_dir;
  dir_e              new_dir;
  logic              wall;
  logic [X_BITS-1:0] next_x;
  logic [Y_BITS-1:0] next_y;

  always_comb begin
    req_dir = dir_e'(direction);
    new_dir = is_reverse(req_dir, heading) ? heading : req_dir;
    wall    = hits_wall(seg_x[0], seg_y[0], new_dir);
    next_x  = step_x(seg_x[0], new_dir);
    next_y  = step_y(seg_y[0], new_dir);
  end

  // Self-collision: the freshly written head against the rest of the
  // already-shifted body, so a vacated tail cell is never matched.
  logic self_hit;

  snake_seg_match #(.SKIP_HEAD(1'b1)) u_self_match (
    .seg_x  (seg_x),
    .seg_y  (seg_y),
    .len    (length_reg),
    .cell_x (seg_x[0]),
    .cell_y (seg_y[0]),
    .hit    (self_hit)
  );

  // Draw-stage occupancy query against the pre-edge buffer
  logic query_match;

  snake_seg_match #(.SKIP_HEAD(1'b0)) u_query_match (
    .seg_x  (seg_x),
    .seg_y  (seg_y),
    .len    (length_reg),
    .cell_x (query_x),
    .cell_y (query_y),
    .hit    (query_match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_x      <= init_x;
      seg_y      <= init_y;
      length_reg <= LEN_START;
      heading    <= DIR_TOP;
      grow_pend  <= 1'b0;
      state      <= ST_RUN;
      moved      <= 1'b0;
      dead       <= 1'b0;
      query_hit  <= 1'b0;
      query_head <= 1'b0;
    end else if (restart) begin
      seg_x      <= init_x;
      seg_y      <= init_y;
      length_reg <= LEN_START;
      heading    <= DIR_TOP;
      grow_pend  <= 1'b0;
      state      <= ST_RUN;
      moved      <= 1'b0;
      dead       <= 1'b0;
      query_hit  <= 1'b0;
      query_head <= 1'b0;
    end else begin
      moved      <= 1'b0;
      query_hit  <= query_match;
      query_head <= (query_x == seg_x[0]) && (query_y == seg_y[0]);

      case (state)
        ST_RUN: begin
          if (grow) begin
            grow_pend <= 1'b1;
          end
          if (step) begin
            heading <= new_dir;
            if (wall) begin
              // Body stays where it was; only the flag and state change
              state <= ST_DEAD;
              dead  <= 1'b1;
            end else begin
              seg_x <= {seg_x[MAX_LEN-2:0], next_x};
              seg_y <= {seg_y[MAX_LEN-2:0], next_y};
              if (grow_pend) begin
                // Growth at full length is consumed but dropped
                if (length_reg != LEN_MAX) begin
                  length_reg <= length_reg + LEN_BITS'(1);
                end
                // A pulse landing on this very edge still counts
                grow_pend <= grow;
              end
              state <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (grow) begin
            grow_pend <= 1'b1;
          end
          if (self_hit) begin
            state <= ST_DEAD;
            dead  <= 1'b1;
          end else begin
            state <= ST_RUN;
            moved <= 1'b1;
          end
        end

        default: begin
          // ST_DEAD: hold everything until restart or reset
        end
      endcase
    end
  end

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];
  assign length = length_reg;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snake_body_ctrl
// Directed scenarios followed by a random walk, all checked against a
// behavioural model that keeps the live body as a queue of cells.
// ---------------------------------------------------------------------------
module tb_snake_body_ctrl;
  import snake_body_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [1:0]          direction = 2'd0;
  logic                step = 1'b0;
  logic                grow = 1'b0;
  logic                restart = 1'b0;
  logic [X_BITS-1:0]   query_x = '0;
  logic [Y_BITS-1:0]   query_y = '0;
  logic                query_hit;
  logic                query_head;
  logic [X_BITS-1:0]   head_x;
  logic [Y_BITS-1:0]   head_y;
  logic [LEN_BITS-1:0] length;
  logic                moved;
  logic                dead;

  snake_body_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .direction  (direction),
    .step       (step),
    .grow       (grow),
    .restart    (restart),
    .query_x    (query_x),
    .query_y    (query_y),
    .query_hit  (query_hit),
    .query_head (query_head),
    .head_x     (head_x),
    .head_y     (head_y),
    .length     (length),
    .moved      (moved),
    .dead       (dead)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------ model
  typedef struct {int x; int y;} cell_t;
  cell_t body[$];
  int    m_len;
  int    m_head;
  bit    m_pend;
  bit    m_dead;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int D_TOP = 0, D_DOWN = 1, D_LEFT = 2, D_RIGHT = 3;

  function automatic int opposite(input int d);
    case (d)
      D_TOP:   return D_DOWN;
      D_DOWN:  return D_TOP;
      D_LEFT:  return D_RIGHT;
      default: return D_LEFT;
    endcase
  endfunction

  function automatic void model_reset();
    body.delete();
    for (int i = 0; i < START_LEN; i++) body.push_back('{START_X, START_Y + i});
    m_len  = START_LEN;
    m_head = D_TOP;
    m_pend = 0;
    m_dead = 0;
  endfunction

  function automatic bit model_hit(input int x, input int y);
    foreach (body[i]) if (body[i].x == x && body[i].y == y) return 1'b1;
    return 1'b0;
  endfunction

  // 0 = ignored (dead), 1 = wall death, 2 = self death, 3 = moved
  function automatic int model_step(input int d);
    int nx, ny;
    if (m_dead) return 0;
    if (d != opposite(m_head)) m_head = d;
    nx = body[0].x;
    ny = body[0].y;
    case (m_head)
      D_TOP:   ny = ny - 1;
      D_DOWN:  ny = ny + 1;
      D_LEFT:  nx = nx - 1;
      default: nx = nx + 1;
    endcase
    if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) begin
      m_dead = 1;
      return 1;
    end
    body.push_front('{nx, ny});
    if (m_pend && m_len < MAX_LEN) m_len++;
    m_pend = 0;
    while (body.size() > m_len) void'(body.pop_back());
    for (int i = 1; i < body.size(); i++)
      if (body[i].x == nx && body[i].y == ny) begin
        m_dead = 1;
        return 2;
      end
    return 3;
  endfunction

  // ------------------------------------------------------------ checking
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".head_x"}, 32'(head_x), 32'(body[0].x));
    chk({tag, ".head_y"}, 32'(head_y), 32'(body[0].y));
    chk({tag, ".length"}, 32'(length), 32'(m_len));
    chk({tag, ".dead"},   32'(dead),   32'(m_dead));
  endtask

  task automatic do_query(input int x, input int y, input string tag);
    query_x = X_BITS'(x);
    query_y = Y_BITS'(y);
    @(posedge clk); #1;
    chk({tag, ".hit"},  32'(query_hit),  32'(model_hit(x, y)));
    chk({tag, ".head"}, 32'(query_head), 32'(body[0].x == x && body[0].y == y));
    $display("query %s (%0d,%0d) hit=%0b head=%0b", tag, x, y, query_hit, query_head);
  endtask

  task automatic do_grow();
    grow = 1'b1;
    @(posedge clk); #1;
    grow = 1'b0;
    if (!m_dead) m_pend = 1;
  endtask

  // One step tick, then observe N+1, N+2, and one idle cycle
  task automatic do_step(input int d, input string tag);
    int r;
    direction = 2'(d);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    r = model_step(d);
    chk({tag, ".n1_dead"},  32'(dead),  32'(r <= 1));
    chk({tag, ".n1_moved"}, 32'(moved), 32'd0);
    chk({tag, ".n1_hx"},    32'(head_x), 32'(body[0].x));
    chk({tag, ".n1_hy"},    32'(head_y), 32'(body[0].y));
    @(posedge clk); #1;
    chk({tag, ".n2_moved"}, 32'(moved), 32'(r == 3));
    chk_state({tag, ".n2"});
    @(posedge clk); #1;
    chk({tag, ".n3_moved"}, 32'(moved), 32'd0);
    @(posedge clk); #1;
    $display("step %s dir=%0d result=%0d head=(%0d,%0d) len=%0d dead=%0b",
             tag, d, r, head_x, head_y, length, dead);
  endtask

  // Restart asserted together with step and grow: restart must win
  task automatic do_restart(input string tag);
    restart = 1'b1;
    step    = 1'b1;
    grow    = 1'b1;
    direction = 2'(D_LEFT);
    @(posedge clk); #1;
    restart = 1'b0;
    step    = 1'b0;
    grow    = 1'b0;
    model_reset();
    chk_state(tag);
    chk({tag, ".moved"}, 32'(moved),      32'd0);
    chk({tag, ".qhit"},  32'(query_hit),  32'd0);
    chk({tag, ".qhead"}, 32'(query_head), 32'd0);
    $display("restart %s head=(%0d,%0d) len=%0d", tag, head_x, head_y, length);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y;
    model_reset();

    // 1: reset state, including during reset
    repeat (3) @(posedge clk);
    #1;
    chk_state("t1_in_reset");
    chk("t1_in_reset.moved", 32'(moved), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_state("t1");
    do_query(20, 17, "t1_tail");
    do_query(20, 18, "t1_below");
    do_query(20, 15, "t1_head");
    do_query(20, 16, "t1_mid");

    // 2: three steps upward
    for (int i = 0; i < 3; i++) do_step(D_TOP, "t2");
    chk("t2.head_y_const", 32'(head_y), 32'd12);
    do_query(20, 14, "t2_tail");
    do_query(20, 15, "t2_vacated");
    do_query(20, 12, "t2_head");

    // 3: growth keeps the old tail cell
    do_grow();
    do_step(D_TOP, "t3");
    chk("t3.len_const", 32'(length), 32'd4);
    do_query(body[body.size()-1].x, body[body.size()-1].y, "t3_oldtail");

    // 4: wall death, dead state ignores step/grow, restart
    while (body[0].y > 0) do_step(D_TOP, "t4_walk");
    do_step(D_TOP, "t4_wall");
    chk("t4.dead_const", 32'(dead), 32'd1);
    do_grow();
    do_step(D_RIGHT, "t4_ignored");
    do_query(body[0].x, body[0].y, "t4_deadq");
    do_restart("t4_restart");
    do_query(20, 17, "t4_tail");
    do_query(20, 15, "t4_head");

    // 5: reversal rejected, then turn right
    do_step(D_DOWN, "t5_rev");
    chk("t5.rev_y_const", 32'(head_y), 32'd14);
    do_step(D_RIGHT, "t5_right");
    chk("t5.right_x_const", 32'(head_x), 32'd21);

    // 6a: square loop at length 4 survives
    do_restart("t6a_restart");
    do_grow();
    do_step(D_TOP, "t6a_grow");
    do_step(D_RIGHT, "t6a_r");
    do_step(D_DOWN,  "t6a_d");
    do_step(D_LEFT,  "t6a_l");
    chk("t6a.alive_const", 32'(dead), 32'd0);

    // 6b: same loop at length 5 bites itself
    do_restart("t6b_restart");
    do_grow();
    do_step(D_TOP, "t6b_grow1");
    do_grow();
    do_step(D_TOP, "t6b_grow2");
    do_step(D_RIGHT, "t6b_r");
    do_step(D_DOWN,  "t6b_d");
    do_step(D_LEFT,  "t6b_l");
    chk("t6b.dead_const", 32'(dead), 32'd1);

    // 3b: grow on every step of an L-shaped path, saturating at MAX_LEN
    do_restart("t3b_restart");
    for (int i = 0; i < 14; i++) begin do_grow(); do_step(D_TOP,   "t3b_up");    end
    for (int i = 0; i < 18; i++) begin do_grow(); do_step(D_RIGHT, "t3b_right"); end
    for (int i = 0; i < 27; i++) begin do_grow(); do_step(D_DOWN,  "t3b_down");  end
    chk("t3b.len_max_const", 32'(length), 32'd32);
    do_query(body[MAX_LEN-1].x, body[MAX_LEN-1].y, "t3b_tail");

    // Random walk
    do_restart("rnd_restart");
    for (int i = 0; i < 200; i++) begin
      if (m_dead) do_restart("rnd_restart");
      if ($urandom_range(3) == 0) do_grow();
      do_step(int'($urandom_range(3)), "rnd");
      if ($urandom_range(1) == 0) begin
        int k;
        k = int'($urandom_range(body.size() - 1));
        x = body[k].x;
        y = body[k].y;
      end else begin
        x = int'($urandom_range(GRID_W - 1));
        y = int'($urandom_range(GRID_H - 1));
      end
      do_query(x, y, "rnd_q");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
